// File: rtl/sram_wr_ctrl.sv
// Streams one load of words into the weight SRAM, then the vector SRAM; write port is registered (1-cycle accept->strobe).
// Backpressure: in_ready is a pure state decode, high only while loading; abort cancels after the same-cycle beat.
module sram_wr_ctrl #(
  parameter int DATA_W  = 32,
  parameter int W_DEPTH = 64,
  parameter int V_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sram_wen_w,
  output logic [5:0]        sram_waddr_w,
  output logic [DATA_W-1:0] sram_wdata_w,
  output logic              sram_wen_v,
  output logic [4:0]        sram_waddr_v,
  output logic [DATA_W-1:0] sram_wdata_v,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_V, DONE} state_e;

  localparam logic [5:0] W_LAST = 6'(W_DEPTH - 1);
  localparam logic [5:0] V_LAST = 6'(V_DEPTH - 1);

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                wen_w_q, wen_w_d;
  logic [5:0]          waddr_w_q, waddr_w_d;
  logic [DATA_W-1:0]   wdata_w_q, wdata_w_d;
  logic                wen_v_q, wen_v_d;
  logic [4:0]          waddr_v_q, waddr_v_d;
  logic [DATA_W-1:0]   wdata_v_q, wdata_v_d;
  logic                done_q, done_d;
  logic                loading;
  logic                accept;

  assign loading = (state_q == LOAD_W) || (state_q == LOAD_V);
  assign accept  = in_valid & loading;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wen_w_d   = 1'b0;
    waddr_w_d = waddr_w_q;
    wdata_w_d = wdata_w_q;
    wen_v_d   = 1'b0;
    waddr_v_d = waddr_v_q;
    wdata_v_d = wdata_v_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = 6'd0;
        end
      end
      LOAD_W: begin
        if (accept) begin
          wen_w_d   = 1'b1;
          waddr_w_d = cnt_q;
          wdata_w_d = in_data;
          cnt_d     = cnt_q + 6'd1;
          if (cnt_q == W_LAST) begin
            state_d = LOAD_V;
            cnt_d   = 6'd0;
          end
        end
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      end
      LOAD_V: begin
        if (accept) begin
          wen_v_d   = 1'b1;
          waddr_v_d = cnt_q[4:0];
          wdata_v_d = in_data;
          cnt_d     = cnt_q + 6'd1;
          if (cnt_q == V_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        // abort beats a coincident final beat: the write still lands, but no completion
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          done_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      wen_w_q   <= 1'b0;
      waddr_w_q <= 6'd0;
      wdata_w_q <= '0;
      wen_v_q   <= 1'b0;
      waddr_v_q <= 5'd0;
      wdata_v_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wen_w_q   <= wen_w_d;
      waddr_w_q <= waddr_w_d;
      wdata_w_q <= wdata_w_d;
      wen_v_q   <= wen_v_d;
      waddr_v_q <= waddr_v_d;
      wdata_v_q <= wdata_v_d;
      done_q    <= done_d;
    end
  end

  assign in_ready     = loading;
  assign busy         = loading;
  assign sram_wen_w   = wen_w_q;
  assign sram_waddr_w = waddr_w_q;
  assign sram_wdata_w = wdata_w_q;
  assign sram_wen_v   = wen_v_q;
  assign sram_waddr_v = waddr_v_q;
  assign sram_wdata_v = wdata_v_q;
  assign load_done    = done_q;

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Scoreboard bench for sram_wr_ctrl: a load-level model predicts every SRAM write; a monitor checks them as they appear.
module tb_sram_wr_ctrl;
  localparam int DW = 32;
  localparam int W  = 64;
  localparam int V  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, sram_wen_w, sram_wen_v, busy, load_done;
  logic [5:0]    sram_waddr_w;
  logic [4:0]    sram_waddr_v;
  logic [DW-1:0] sram_wdata_w, sram_wdata_v;

  sram_wr_ctrl #(.DATA_W(DW), .W_DEPTH(W), .V_DEPTH(V)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sram_wen_w(sram_wen_w), .sram_waddr_w(sram_waddr_w), .sram_wdata_w(sram_wdata_w),
    .sram_wen_v(sram_wen_v), .sram_waddr_v(sram_waddr_v), .sram_wdata_v(sram_wdata_v),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;   // 0 = weight, 1 = vector
    int          addr;
    logic [DW-1:0] data;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model: a load is one sequence of W+V words indexed by mk.
  bit mbusy = 0;
  bit mdone = 0;
  int mk = 0;

  logic [5:0]    last_aw = '0;
  logic [4:0]    last_av = '0;
  logic [DW-1:0] last_dw = '0, last_dv = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_aw = '0; last_av = '0; last_dw = '0; last_dv = '0;
    end else begin
      if (sram_wen_w && sram_wen_v) chk("wen_exclusive", 1, 0);
      if (sram_wen_w || sram_wen_v || load_done) begin
        if (q.size() == 0) begin
          chk("spurious_write", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("wen_w", sram_wen_w, !e.port);
          chk("wen_v", sram_wen_v, e.port);
          chk("load_done", load_done, e.done);
          if (!e.port) begin
            chk("waddr_w", sram_waddr_w, e.addr);
            chk("wdata_w", sram_wdata_w, e.data);
            last_aw = 6'(e.addr); last_dw = e.data;
          end else begin
            chk("waddr_v", sram_waddr_v, e.addr);
            chk("wdata_v", sram_wdata_v, e.data);
            last_av = 5'(e.addr); last_dv = e.data;
          end
        end
      end
      if (!sram_wen_w) begin
        chk("hold_waddr_w", sram_waddr_w, last_aw);
        chk("hold_wdata_w", sram_wdata_w, last_dw);
      end
      if (!sram_wen_v) begin
        chk("hold_waddr_v", sram_waddr_v, last_av);
        chk("hold_wdata_v", sram_wdata_v, last_dv);
      end
    end
  end

  task automatic step(bit st, bit ab, bit v, logic [DW-1:0] d);
    @(negedge clk);
    chk("in_ready", in_ready, mbusy);
    chk("busy", busy, mbusy);
    start = st; abort = ab; in_valid = v; in_data = d;
    if (mbusy) begin
      if (v) begin
        exp_t e;
        e.port = (mk >= W);
        e.addr = (mk >= W) ? mk - W : mk;
        e.data = d;
        e.done = (mk == W + V - 1) && !ab;
        e.cyc  = cyc + 1;
        q.push_back(e);
        mk++;
      end
      if (ab) begin
        mbusy = 0; mk = 0;
      end else if (mk == W + V) begin
        mbusy = 0; mdone = 1; mk = 0;
      end
    end else if (mdone) begin
      mdone = 0;
    end else if (st) begin
      mbusy = 1; mk = 0;
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_wen_w"}, sram_wen_w, 0);
    chk({tag, "_wen_v"}, sram_wen_v, 0);
    chk({tag, "_waddr_w"}, sram_waddr_w, 0);
    chk({tag, "_waddr_v"}, sram_waddr_v, 0);
    chk({tag, "_wdata_w"}, sram_wdata_w, 0);
    chk({tag, "_wdata_v"}, sram_wdata_v, 0);
  endtask

  // Reset between clock edges so the clear must be asynchronous.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    mbusy = 0; mdone = 0; mk = 0;
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); abort = 1'($urandom); in_valid = 1'($urandom); in_data = $urandom;
    end
    @(negedge clk);
    start = 0; abort = 0; in_valid = 0; in_data = '0;
    rst_n = 1'b1;
  endtask

  // abort_at/start_at/reset_at are word indices within the load; -1 disables.
  task automatic run_load(int pct, bit rand_data, int abort_at, int start_at, int reset_at);
    int guard;
    bit v;
    guard = 0;
    step(1, 0, 0, '0);
    while (mbusy && guard < 2000) begin
      if (mk == reset_at) begin
        do_reset();
      end else begin
        v = ($urandom_range(99) < pct);
        step(mk == start_at, v && (mk == abort_at), v,
             v ? (rand_data ? DW'($urandom) : DW'(mk)) : DW'($urandom));
      end
      guard++;
    end
    if (guard >= 2000) chk("load_timeout", 1, 0);
    step(0, 0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 0; abort = 0; in_valid = 0; in_data = '0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); abort = 1'($urandom); in_valid = 1'($urandom); in_data = $urandom;
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    start = 0; abort = 0; in_valid = 0;
    rst_n = 1'b1;
    // idle with traffic but no start: nothing may be written, abort is inert
    repeat (4) step(0, 1'($urandom), 1, $urandom);

    run_load(100, 0, -1, -1, -1);          // full streaming, data = index
    run_load(50, 1, -1, -1, -1);           // bubbly stream
    run_load(100, 0, -1, 10, -1);          // start during LOAD_W ignored
    run_load(100, 0, 20, -1, -1);          // abort at weight word 20
    repeat (3) step(0, 0, 1, $urandom);
    run_load(70, 1, -1, -1, -1);           // reload after abort from addr 0
    run_load(100, 0, W + V - 1, -1, -1);   // abort coincident with final beat
    repeat (2) step(0, 0, 1, $urandom);
    run_load(100, 0, -1, -1, W + 5);       // async reset at vector word 5
    repeat (2) step(0, 0, 1, $urandom);
    run_load(60, 1, -1, -1, -1);

    repeat (4) step(0, 0, 0, '0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
